// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM states, run modes and stop causes.
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_STEP_WAIT,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        MODE_FREE = 2'd0,
        MODE_STEP = 2'd1,
        MODE_BP   = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        CAUSE_BUDGET = 2'd0,
        CAUSE_BP     = 2'd1,
        CAUSE_ABORT  = 2'd2,
        CAUSE_SAT    = 2'd3
    } cause_t;

    // Mode code 3 has no meaning of its own and behaves as free-run.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_STEP;
            2'd2:    return MODE_BP;
            default: return MODE_FREE;
        endcase
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module cpu_run_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         sat
);

    assign sat = &cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !sat)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the lab CPU: reset sequencing, then free-run, single-step
// or run-to-breakpoint through a clock enable, reporting why the run stopped.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16,
    parameter int RST_HOLD  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] budget,
    input  logic                 step,
    input  logic                 abort,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic [PC_WIDTH-1:0]  cpu_pc,
    output logic                 cpu_rst,
    output logic                 cpu_en,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           stop_cause,
    output logic [CNT_WIDTH-1:0] cycle_cnt
);

    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SAT_LAST  = ~ONE;
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RST_HOLD - 1);

    state_t                state;
    mode_t                 mode_q;
    cause_t                cause_q, cause_nxt;
    logic [CNT_WIDTH-1:0]  budget_q;
    logic [PC_WIDTH-1:0]   bp_q;
    logic [CNT_WIDTH-1:0]  hold_cnt;
    logic                  hold_sat, hold_last, cyc_sat;
    logic                  active, hit_abort, hit_bp, hit_budget, hit_sat, stop;

    assign stop_cause = cause_q;
    assign hold_last  = (hold_cnt == HOLD_LAST) || hold_sat;

    cpu_run_ctrl_sat_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == S_IDLE && start),
        .en  (cpu_en),
        .cnt (cycle_cnt),
        .sat (cyc_sat)
    );

    cpu_run_ctrl_sat_counter #(.W(CNT_WIDTH)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == S_IDLE),
        .en  (state == S_RESET),
        .cnt (hold_cnt),
        .sat (hold_sat)
    );

    // Abort and breakpoint gate cpu_en in the same cycle; budget and saturation
    // are detected on the last enabled cycle so done follows it immediately.
    always_comb begin
        active     = (state == S_RESET) || (state == S_RUN) || (state == S_STEP_WAIT);
        hit_abort  = active && abort;
        hit_bp     = active && (mode_q == MODE_BP) && (cpu_pc == bp_q);
        cpu_en     = (state == S_RUN) && !hit_abort && !hit_bp;
        hit_budget = cpu_en && (budget_q != '0) && (cycle_cnt == budget_q - ONE);
        hit_sat    = active && (cyc_sat || (cpu_en && cycle_cnt == SAT_LAST));
        stop       = hit_abort || hit_bp || hit_budget || hit_sat;
        if (hit_abort)
            cause_nxt = CAUSE_ABORT;
        else if (hit_bp)
            cause_nxt = CAUSE_BP;
        else if (hit_budget)
            cause_nxt = CAUSE_BUDGET;
        else
            cause_nxt = CAUSE_SAT;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            mode_q   <= MODE_FREE;
            budget_q <= '0;
            bp_q     <= '0;
            cause_q  <= CAUSE_BUDGET;
            cpu_rst  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= S_HALT;
                cause_q <= cause_nxt;
                cpu_rst <= 1'b1;
                done    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        cpu_rst <= 1'b1;
                        if (start) begin
                            mode_q   <= decode_mode(mode);
                            budget_q <= budget;
                            bp_q     <= bp_addr;
                            cause_q  <= CAUSE_BUDGET;
                            cpu_rst  <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_RESET;
                        end
                    end
                    S_RESET: begin
                        if (hold_last) begin
                            cpu_rst <= 1'b1;
                            state   <= (mode_q == MODE_STEP) ? S_STEP_WAIT : S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (mode_q == MODE_STEP)
                            state <= S_STEP_WAIT;
                    end
                    S_STEP_WAIT: begin
                        if (step)
                            state <= S_RUN;
                    end
                    S_HALT: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
